// File: rtl/avmm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave between NUM_MASTERS masters, with write-burst
// grant lock and read-return routing. Define AVMM_ARB_STATS_EN to add per-master grant counters.
module avmm_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int NUM_SYMBOLS = 4,
    parameter int BURST_W     = 4,
    parameter int MAX_PENDING = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0]  m_address,
    input  logic [NUM_MASTERS*BURST_W-1:0] m_burstcount,
    input  logic [NUM_MASTERS-1:0]         m_read,
    input  logic [NUM_MASTERS-1:0]         m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0]  m_writedata,
    input  logic [NUM_MASTERS*NUM_SYMBOLS-1:0] m_byteenable,
    output logic [NUM_MASTERS-1:0]         m_waitrequest,
    output logic [DATA_W-1:0]              m_readdata,
    output logic [NUM_MASTERS-1:0]         m_readdatavalid,
    output logic [ADDR_W-1:0]              s_address,
    output logic [BURST_W-1:0]             s_burstcount,
    output logic                           s_read,
    output logic                           s_write,
    output logic [DATA_W-1:0]              s_writedata,
    output logic [NUM_SYMBOLS-1:0]         s_byteenable,
    input  logic                           s_waitrequest,
    input  logic [DATA_W-1:0]              s_readdata,
    input  logic                           s_readdatavalid
`ifdef AVMM_ARB_STATS_EN
    ,
    output logic [NUM_MASTERS*16-1:0]      grant_count
`endif
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int FA_W  = $clog2(MAX_PENDING);
    localparam int PTR_W = FA_W + 1;

    typedef enum logic {IDLE, WBURST} state_t;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     lock_idx;
    logic [IDX_W-1:0]     gnt;
    logic [IDX_W-1:0]     sel;
    logic                 found;
    int unsigned          scan;
    logic [BURST_W-1:0]   wr_beats;
    logic [BURST_W-1:0]   head_cnt;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [IDX_W-1:0]     fifo_idx [MAX_PENDING];
    logic [BURST_W-1:0]   fifo_len [MAX_PENDING];
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 accept;
    logic                 rvalid;
    logic [NUM_MASTERS-1:0] req;
    logic [IDX_W-1:0]     head_idx;
    logic [BURST_W-1:0]   head_len;
    logic [BURST_W-1:0]   push_len;

    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[FA_W-1:0] == rd_ptr[FA_W-1:0]);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign req        = m_write | (m_read & {NUM_MASTERS{~fifo_full}});

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        gnt   = rr_ptr;
        found = 1'b0;
        scan  = 0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            scan = (32'(rr_ptr) + k) % NUM_MASTERS;
            if (!found && req[IDX_W'(scan)]) begin
                found = 1'b1;
                gnt   = IDX_W'(scan);
            end
        end
    end

    assign sel = (state == WBURST) ? lock_idx : gnt;

    always_comb begin
        s_address     = m_address[sel*ADDR_W +: ADDR_W];
        s_burstcount  = m_burstcount[sel*BURST_W +: BURST_W];
        s_writedata   = m_writedata[sel*DATA_W +: DATA_W];
        s_byteenable  = m_byteenable[sel*NUM_SYMBOLS +: NUM_SYMBOLS];
        s_read        = 1'b0;
        s_write       = 1'b0;
        m_waitrequest = '1;
        if (!reset) begin
            if (state == WBURST) begin
                s_write            = m_write[sel];
                m_waitrequest[sel] = s_waitrequest;
            end else if (found) begin
                s_write            = m_write[sel];
                s_read             = !m_write[sel];
                m_waitrequest[sel] = s_waitrequest;
            end
        end
    end

    assign accept   = (s_read | s_write) & !s_waitrequest;
    assign push     = accept & s_read;
    assign push_len = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;

    assign head_idx = fifo_idx[rd_ptr[FA_W-1:0]];
    assign head_len = fifo_len[rd_ptr[FA_W-1:0]];
    assign rvalid   = s_readdatavalid & !fifo_empty & !reset;
    assign pop      = rvalid && ((head_cnt + BURST_W'(1)) == head_len);

    assign m_readdata = s_readdata;

    always_comb begin
        m_readdatavalid = '0;
        if (rvalid) m_readdatavalid[head_idx] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
            wr_beats <= '0;
            head_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                head_cnt <= '0;
            end else if (rvalid) begin
                head_cnt <= head_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr <= (gnt == IDX_W'(NUM_MASTERS - 1)) ? '0 : gnt + 1'b1;
                        if (s_write && (s_burstcount > BURST_W'(1))) begin
                            lock_idx <= gnt;
                            wr_beats <= s_burstcount - 1'b1;
                            state    <= WBURST;
                        end
                    end
                end
                WBURST: begin
                    if (accept) begin
                        wr_beats <= wr_beats - 1'b1;
                        if (wr_beats == BURST_W'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tracking storage needs no reset: validity is carried entirely by the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_idx[wr_ptr[FA_W-1:0]] <= gnt;
            fifo_len[wr_ptr[FA_W-1:0]] <= push_len;
        end
    end

`ifdef AVMM_ARB_STATS_EN
    // Only IDLE accepts are first beats; burst continuations happen in WBURST.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_count <= '0;
        end else if (accept && (state == IDLE) && (grant_count[gnt*16 +: 16] != 16'hFFFF)) begin
            grant_count[gnt*16 +: 16] <= grant_count[gnt*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_avmm_rr_arbiter.sv
// Directed self-checking bench for avmm_rr_arbiter (2 masters, 4-deep read tracking).
module tb_avmm_rr_arbiter;
    localparam int NM = 2;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int BW = 4;
    localparam int MP = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [NM*AW-1:0]     m_address;
    logic [NM*BW-1:0]     m_burstcount;
    logic [NM-1:0]        m_read;
    logic [NM-1:0]        m_write;
    logic [NM*DW-1:0]     m_writedata;
    logic [NM*NS-1:0]     m_byteenable;
    logic [NM-1:0]        m_waitrequest;
    logic [DW-1:0]        m_readdata;
    logic [NM-1:0]        m_readdatavalid;
    logic [AW-1:0]        s_address;
    logic [BW-1:0]        s_burstcount;
    logic                 s_read;
    logic                 s_write;
    logic [DW-1:0]        s_writedata;
    logic [NS-1:0]        s_byteenable;
    logic                 s_waitrequest;
    logic [DW-1:0]        s_readdata;
    logic                 s_readdatavalid;
`ifdef AVMM_ARB_STATS_EN
    logic [NM*16-1:0]     grant_count;
`endif

    avmm_rr_arbiter #(
        .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW),
        .NUM_SYMBOLS(NS), .BURST_W(BW), .MAX_PENDING(MP)
    ) dut (
        .clock(clock), .reset(reset),
        .m_address(m_address), .m_burstcount(m_burstcount),
        .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid),
        .s_address(s_address), .s_burstcount(s_burstcount),
        .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid)
`ifdef AVMM_ARB_STATS_EN
        , .grant_count(grant_count)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int gap[5]  = '{0, 2, 1, 3, 0};
    logic [NM-1:0] rdv_exp[5] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_m();
        m_read = '0; m_write = '0; m_address = '0; m_burstcount = '0;
        m_writedata = '0; m_byteenable = '0;
    endtask

    task automatic drv(input int i, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] bc, input logic [DW-1:0] d);
        m_read[i] = rd;
        m_write[i] = wr;
        m_address[i*AW +: AW] = a;
        m_burstcount[i*BW +: BW] = bc;
        m_writedata[i*DW +: DW] = d;
        m_byteenable[i*NS +: NS] = '1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        int k0, k1, e, bt;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_d;

        idle_m();
        s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;

        // Reset: outputs forced idle even with requests pending
        step();
        drv(0, 1'b0, 1'b1, 12'h001, 4'd1, 32'h1);
        drv(1, 1'b1, 1'b1, 12'h002, 4'd1, 32'h2);
        s_readdatavalid = 1'b1;
        settle();
        chk("rst_s_write", s_write, 1'b0);
        chk("rst_s_read", s_read, 1'b0);
        chk("rst_wait", m_waitrequest, 2'b11);
        chk("rst_rdv", m_readdatavalid, 2'b00);
        step();
        reset = 1'b0; idle_m(); s_readdatavalid = 1'b0;

        // Concurrent single writes alternate 0,1,0,1,...
        k0 = 0; k1 = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            idle_m();
            if (k0 < 10) drv(0, 1'b0, 1'b1, 12'(12'h100 + k0), 4'd1, 32'hA000_0000 + k0);
            if (k1 < 10) drv(1, 1'b0, 1'b1, 12'(12'h200 + k1), 4'd1, 32'hB000_0000 + k1);
            settle();
            e = c % 2;
            exp_a = (e == 1) ? 12'(12'h200 + k1) : 12'(12'h100 + k0);
            exp_d = (e == 1) ? 32'hB000_0000 + k1 : 32'hA000_0000 + k0;
            chk("rr_s_write", s_write, 1'b1);
            chk("rr_addr", s_address, exp_a);
            chk("rr_data", s_writedata, exp_d);
            chk("rr_wait", m_waitrequest, (e == 1) ? 2'b01 : 2'b10);
            if (e == 1) k1++; else k0++;
        end

        // One write from master 0 moves the pointer to master 1
        step(); idle_m();
        drv(0, 1'b0, 1'b1, 12'h3F0, 4'd1, 32'h55);
        settle();
        chk("preb_wait", m_waitrequest, 2'b10);

        // Master 1 burst of 4 locks out master 0's read; one slave stall mid-burst
        bt = 0;
        for (int c = 0; c < 5; c++) begin
            step(); idle_m();
            drv(0, 1'b1, 1'b0, 12'h020, 4'd1, 32'h0);
            drv(1, 1'b0, 1'b1, 12'h010, 4'd4, 32'hC000_0000 + bt);
            s_waitrequest = (c == 2);
            settle();
            chk("wb_s_write", s_write, 1'b1);
            chk("wb_s_read", s_read, 1'b0);
            chk("wb_addr", s_address, 12'h010);
            chk("wb_bc", s_burstcount, 4'd4);
            chk("wb_data", s_writedata, 32'hC000_0000 + bt);
            chk("wb_wait", m_waitrequest, (c == 2) ? 2'b11 : 2'b01);
            if (c != 2) bt++;
        end
        step(); idle_m(); s_waitrequest = 1'b0;
        drv(0, 1'b1, 1'b0, 12'h020, 4'd1, 32'h0);
        settle();
        chk("postb_s_read", s_read, 1'b1);
        chk("postb_s_write", s_write, 1'b0);
        chk("postb_addr", s_address, 12'h020);
        chk("postb_wait", m_waitrequest, 2'b10);
        step(); idle_m();
        s_readdatavalid = 1'b1; s_readdata = 32'hDEAD_0001;
        settle();
        chk("postb_rdv", m_readdatavalid, 2'b01);
        chk("postb_rdata", m_readdata, 32'hDEAD_0001);

        // Two read bursts, returns routed in order with gaps
        step(); idle_m(); s_readdatavalid = 1'b0;
        drv(0, 1'b1, 1'b0, 12'h004, 4'd3, 32'h0);
        settle();
        chk("rd0_s_read", s_read, 1'b1);
        chk("rd0_addr", s_address, 12'h004);
        chk("rd0_bc", s_burstcount, 4'd3);
        chk("rd0_wait", m_waitrequest, 2'b10);
        step(); idle_m();
        drv(1, 1'b1, 1'b0, 12'h008, 4'd2, 32'h0);
        settle();
        chk("rd1_addr", s_address, 12'h008);
        chk("rd1_bc", s_burstcount, 4'd2);
        chk("rd1_wait", m_waitrequest, 2'b01);
        for (int b = 0; b < 5; b++) begin
            for (int g = 0; g < gap[b]; g++) begin
                step(); idle_m(); s_readdatavalid = 1'b0;
                settle();
                chk("ret_gap", m_readdatavalid, 2'b00);
            end
            step(); idle_m();
            s_readdatavalid = 1'b1; s_readdata = 32'hE000_0000 + b;
            settle();
            chk("ret_rdv", m_readdatavalid, rdv_exp[b]);
            chk("ret_data", m_readdata, 32'hE000_0000 + b);
        end

        // Return with nothing outstanding is dropped
        step(); idle_m(); s_readdatavalid = 1'b1;
        settle();
        chk("orphan_rdv", m_readdatavalid, 2'b00);

        // Tracking FIFO full: 5th read held until the first response pops
        step(); idle_m(); s_readdatavalid = 1'b0;
        drv(0, 1'b1, 1'b0, 12'h040, 4'd2, 32'h0);
        settle();
        chk("full_rd1_wait", m_waitrequest, 2'b10);
        for (int i = 1; i < 4; i++) begin
            step(); idle_m();
            drv(0, 1'b1, 1'b0, 12'(12'h040 + i), 4'd1, 32'h0);
            settle();
            chk("full_rdn_wait", m_waitrequest, 2'b10);
        end
        for (int i = 0; i < 2; i++) begin
            step(); idle_m();
            drv(0, 1'b1, 1'b0, 12'h050, 4'd1, 32'h0);
            settle();
            chk("full_rd5_s_read", s_read, 1'b0);
            chk("full_rd5_wait", m_waitrequest, 2'b11);
        end
        for (int i = 0; i < 2; i++) begin
            step(); s_readdatavalid = 1'b1; s_readdata = 32'hF000_0000 + i;
            settle();
            chk("full_ret_rdv", m_readdatavalid, 2'b01);
            chk("full_ret_wait", m_waitrequest, 2'b11);
        end
        step(); s_readdatavalid = 1'b0;
        settle();
        chk("full_rd5_go", s_read, 1'b1);
        chk("full_rd5_addr", s_address, 12'h050);
        chk("full_rd5_wait_go", m_waitrequest, 2'b10);
        for (int i = 0; i < 4; i++) begin
            step(); idle_m(); s_readdatavalid = 1'b1;
            settle();
            chk("drain_rdv", m_readdatavalid, 2'b01);
        end

        // Reset mid-burst with a read outstanding
        step(); idle_m(); s_readdatavalid = 1'b0;
        drv(1, 1'b1, 1'b0, 12'h060, 4'd1, 32'h0);
        settle();
        chk("pre_rst_rd_wait", m_waitrequest, 2'b01);
        step(); idle_m();
        drv(0, 1'b0, 1'b1, 12'h070, 4'd4, 32'hF0);
        settle();
        chk("pre_rst_wb_wait", m_waitrequest, 2'b10);
        step(); reset = 1'b1;
        drv(0, 1'b0, 1'b1, 12'h070, 4'd4, 32'hF1);
        settle();
        chk("midrst_s_write", s_write, 1'b0);
        chk("midrst_s_read", s_read, 1'b0);
        chk("midrst_wait", m_waitrequest, 2'b11);
        step(); reset = 1'b0; idle_m();
        drv(0, 1'b0, 1'b1, 12'h080, 4'd1, 32'h80);
        drv(1, 1'b0, 1'b1, 12'h090, 4'd1, 32'h90);
        settle();
        chk("postrst_wait", m_waitrequest, 2'b10);
        chk("postrst_addr", s_address, 12'h080);
        step(); idle_m(); s_readdatavalid = 1'b1;
        settle();
        chk("postrst_rdv", m_readdatavalid, 2'b00);

`ifdef AVMM_ARB_STATS_EN
        step(); s_readdatavalid = 1'b0; reset = 1'b1;
        step(); reset = 1'b0;
        for (int b = 0; b < 3; b++)
            for (int t = 0; t < 4; t++) begin
                step(); idle_m();
                drv(0, 1'b0, 1'b1, 12'h100, 4'd4, 32'(t));
            end
        for (int s = 0; s < 2; s++) begin
            step(); idle_m();
            drv(1, 1'b0, 1'b1, 12'(12'h200 + s), 4'd1, 32'(s));
        end
        step(); idle_m();
        settle();
        chk("grant_count", grant_count, 32'h0002_0003);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
